text_console: RTL and testbench
===============================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 160, SHALL set the number of text columns per row (1..256).
REQ-002 Parameter ROWS, default 60, SHALL set the number of text rows (1..64).
REQ-003 Parameter FILL, default 8'h20, SHALL set the blank-cell character code.
REQ-004 clk48  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 in_data  input  8  SHALL carry the incoming character byte.
REQ-007 in_valid  input  1  SHALL indicate that in_data is valid.
REQ-008 in_ready  output  1  SHALL indicate that a byte is accepted this cycle.
REQ-009 vga_waddr  output  14  SHALL carry the text-buffer write address {row[5:0], col[7:0]}.
REQ-010 vga_wdata  output  8  SHALL carry the text-buffer write character.
REQ-011 vga_wr_en  output  1  SHALL be the single-cycle text-buffer write strobe.
REQ-012 cursor_col / cursor_row  output  8 / 6  SHALL give the current cursor position.
REQ-013 busy  output  1  SHALL be high while any clear operation is in progress.

Function
REQ-014 All outputs SHALL be registered; handshake = in_valid && in_ready on one clock edge.
REQ-015 FSM states SHALL be CLEAR_ALL, IDLE and CLEAR_LINE; in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in CLEAR_ALL and CLEAR_LINE.
REQ-016 CLEAR_ALL SHALL write FILL to every cell, row-major, one cell per cycle (ROWS*COLS writes), then go to IDLE with cursor (0,0).
REQ-017 Printable byte (0x20..0x7E) accepted at cursor (r,c) SHALL produce, on the next cycle, vga_wr_en=1, vga_waddr={r,c}, vga_wdata=byte; the cursor SHALL advance to c+1.
REQ-018 If the advanced column equals COLS, the block SHALL perform a newline (REQ-020) instead of holding c=COLS.
REQ-019 0x0D (CR) SHALL set col=0 and SHALL produce no write.
REQ-020 0x0A (LF) or a column overflow SHALL set col=0 and row=row+1, or row=0 when row=ROWS-1, then enter CLEAR_LINE for the new row.
REQ-021 CLEAR_LINE SHALL write FILL to cols 0..COLS-1 of the target row, one per cycle, then return to IDLE.
REQ-022 0x08 (BS) with col>0 SHALL set col=col-1 and write FILL at the new position; with col=0 it SHALL do nothing (no row wrap-back).
REQ-023 All other byte values SHALL be accepted and discarded with no write and no cursor change.
REQ-024 A printable byte at col=COLS-1 SHALL write its own cell first; the CLEAR_LINE writes SHALL start the cycle after it, with no gap and no dropped write.
REQ-025 vga_wr_en SHALL never be high for two different addresses in the same cycle; any non-write cycle SHALL hold vga_wr_en=0.
REQ-026 in_valid without in_ready SHALL leave in_data unconsumed; the source holds it until it is accepted.

Reset
REQ-027 rst=1 SHALL set the cursor to (0,0), vga_wr_en=0, in_ready=0, busy=1, clear counters to 0, and state CLEAR_ALL on the next edge.
REQ-028 rst asserted mid-operation (any state) SHALL abort it and restart CLEAR_ALL from cell (0,0) after release.
REQ-029 The first CLEAR_ALL write SHALL occur in the first cycle after rst deasserts.

Verification
REQ-030 Reset, ROWS=3, COLS=4: expect exactly 12 writes of 0x20 to addresses {0,0}..{2,3} in order, then in_ready=1, busy=0.
REQ-031 In IDLE, send 'A' (0x41) -> next cycle write {0,0}=0x41, cursor (0,1); send 0x08 -> write {0,0}=0x20, cursor (0,0).
REQ-032 With COLS=4, send "ABCD" -> writes to cols 0..3 of row 0, then 4 FILL writes on row 1, in_ready=0 throughout, cursor ends at (1,0).
REQ-033 At row=ROWS-1, send 0x0A -> cursor (0,0), row 0 cleared with FILL, busy=1 for COLS cycles.
REQ-034 Send 0x0D at col 3, then 0x07 -> cursor (r,0), no writes; 0x07 accepted with in_ready=1.
REQ-035 Assert rst during CLEAR_LINE -> CLEAR_ALL restarts at {0,0} and the pending line clear is discarded.

Source files
------------

// File: rtl/text_console.sv
// Character-stream text console: turns a byte stream into text-buffer writes
// with cursor tracking, line wrap, backspace and full/line clears.
module text_console #(
  parameter int          COLS = 160,
  parameter int          ROWS = 60,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [13:0] vga_waddr,
  output logic [7:0]  vga_wdata,
  output logic        vga_wr_en,
  output logic [7:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [8:0] COLS_W   = 9'(COLS);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  state_t      state_q;
  logic [7:0]  cur_col_q, clr_col_q, wdata_q;
  logic [5:0]  cur_row_q, clr_row_q;
  logic [13:0] waddr_q;
  logic        wr_en_q, in_ready_q, busy_q;

  logic        accept_d, printable_d, do_nl_d;
  logic [8:0]  col_inc_d;
  logic [5:0]  row_nx_d;

  always_comb begin
    accept_d    = in_valid && in_ready_q && (state_q == IDLE);
    printable_d = (in_data >= 8'h20) && (in_data <= 8'h7E);
    col_inc_d   = {1'b0, cur_col_q} + 9'd1;
    // Newline comes from LF or from a printable byte filling the last column
    do_nl_d     = (printable_d && (col_inc_d == COLS_W)) || (in_data == 8'h0A);
    row_nx_d    = (cur_row_q == LAST_ROW) ? 6'd0 : cur_row_q + 6'd1;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q    <= CLEAR_ALL;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        CLEAR_ALL: begin
          wr_en_q <= 1'b1;
          waddr_q <= {clr_row_q, clr_col_q};
          wdata_q <= FILL;
          if (clr_col_q == LAST_COL) begin
            clr_col_q <= '0;
            if (clr_row_q == LAST_ROW) begin
              clr_row_q  <= '0;
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              cur_col_q  <= '0;
              cur_row_q  <= '0;
            end else begin
              clr_row_q <= clr_row_q + 6'd1;
            end
          end else begin
            clr_col_q <= clr_col_q + 8'd1;
          end
        end
        CLEAR_LINE: begin
          wr_en_q <= 1'b1;
          waddr_q <= {cur_row_q, clr_col_q};
          wdata_q <= FILL;
          if (clr_col_q == LAST_COL) begin
            clr_col_q  <= '0;
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clr_col_q <= clr_col_q + 8'd1;
          end
        end
        IDLE: begin
          if (accept_d) begin
            if (printable_d) begin
              wr_en_q <= 1'b1;
              waddr_q <= {cur_row_q, cur_col_q};
              wdata_q <= in_data;
            end
            if (do_nl_d) begin
              cur_col_q  <= '0;
              cur_row_q  <= row_nx_d;
              clr_col_q  <= '0;
              state_q    <= CLEAR_LINE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else if (printable_d) begin
              cur_col_q <= col_inc_d[7:0];
            end else if (in_data == 8'h0D) begin
              cur_col_q <= '0;
            end else if ((in_data == 8'h08) && (cur_col_q != 8'd0)) begin
              cur_col_q <= cur_col_q - 8'd1;
              wr_en_q   <= 1'b1;
              waddr_q   <= {cur_row_q, cur_col_q - 8'd1};
              wdata_q   <= FILL;
            end
          end
        end
        default: state_q <= CLEAR_ALL;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign vga_waddr  = waddr_q;
  assign vga_wdata  = wdata_q;
  assign vga_wr_en  = wr_en_q;
  assign cursor_col = cur_col_q;
  assign cursor_row = cur_row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a 3x4 screen: vector table for single
// bytes plus hand-written sequences for clears, wrap and reset abort.
module tb_text_console;
  logic        clk48 = 1'b0;
  logic        rst, in_valid, in_ready, vga_wr_en, busy;
  logic [7:0]  in_data, vga_wdata, cursor_col;
  logic [13:0] vga_waddr;
  logic [5:0]  cursor_row;

  int checks = 0;
  int errors = 0;
  logic [21:0] wq[$];

  text_console #(.COLS(4), .ROWS(3), .FILL(8'h20)) dut (
    .clk48(clk48), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .vga_waddr(vga_waddr), .vga_wdata(vga_wdata),
    .vga_wr_en(vga_wr_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk48 = ~clk48;

  // Write log, sampled mid-cycle
  always @(negedge clk48) if (vga_wr_en) wq.push_back({vga_waddr, vga_wdata});

  typedef struct {
    logic [7:0]  din;
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  dat;
    logic [7:0]  col;
    logic [5:0]  row;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int maxc);
    int n = 0;
    @(negedge clk48);
    while (!in_ready && n < maxc) begin
      n++;
      @(negedge clk48);
    end
    chk("wait_ready_timeout", int'(in_ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(100);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk48);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_clear_all();
    chk("clr_all_count", wq.size(), 12);
    for (int i = 0; i < 12 && i < wq.size(); i++) begin
      chk($sformatf("clr_all_addr%0d", i), int'(wq[i][21:8]), ((i / 4) << 8) | (i % 4));
      chk($sformatf("clr_all_data%0d", i), int'(wq[i][7:0]), 32'h20);
    end
  endtask

  initial begin
    vt[0]  = '{8'h41, 1'b1, 14'h000, 8'h41, 8'd1, 6'd0};
    vt[1]  = '{8'h08, 1'b1, 14'h000, 8'h20, 8'd0, 6'd0};
    vt[2]  = '{8'h08, 1'b0, 14'h000, 8'h00, 8'd0, 6'd0};
    vt[3]  = '{8'h42, 1'b1, 14'h000, 8'h42, 8'd1, 6'd0};
    vt[4]  = '{8'h43, 1'b1, 14'h001, 8'h43, 8'd2, 6'd0};
    vt[5]  = '{8'h44, 1'b1, 14'h002, 8'h44, 8'd3, 6'd0};
    vt[6]  = '{8'h0D, 1'b0, 14'h000, 8'h00, 8'd0, 6'd0};
    vt[7]  = '{8'h07, 1'b0, 14'h000, 8'h00, 8'd0, 6'd0};
    vt[8]  = '{8'h7E, 1'b1, 14'h000, 8'h7E, 8'd1, 6'd0};
    vt[9]  = '{8'h7F, 1'b0, 14'h000, 8'h00, 8'd1, 6'd0};
    vt[10] = '{8'h1F, 1'b0, 14'h000, 8'h00, 8'd1, 6'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk48);
    #1;
    chk("rst_wr_en", int'(vga_wr_en), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cursor", int'({cursor_row, cursor_col}), 0);

    // Power-up clear
    @(negedge clk48); rst = 1'b0; wq.delete();
    @(posedge clk48); #1;
    chk("first_clr_wr", int'(vga_wr_en), 1);
    chk("first_clr_addr", int'(vga_waddr), 0);
    wait_ready(100);
    @(negedge clk48); #1;
    check_clear_all();
    chk("post_clr_busy", int'(busy), 0);
    chk("post_clr_ready", int'(in_ready), 1);

    // Single-byte vectors
    for (int i = 0; i < 11; i++) begin
      send(vt[i].din);
      chk($sformatf("v%0d_wr", i), int'(vga_wr_en), int'(vt[i].wr));
      if (vt[i].wr) begin
        chk($sformatf("v%0d_addr", i), int'(vga_waddr), int'(vt[i].addr));
        chk($sformatf("v%0d_data", i), int'(vga_wdata), int'(vt[i].dat));
      end
      chk($sformatf("v%0d_col", i), int'(cursor_col), int'(vt[i].col));
      chk($sformatf("v%0d_row", i), int'(cursor_row), int'(vt[i].row));
      chk($sformatf("v%0d_ready", i), int'(in_ready), 1);
      @(posedge clk48); #1;
      chk($sformatf("v%0d_single_strobe", i), int'(vga_wr_en), 0);
    end

    // Row wrap: "ABCD" from col 0, last cell then line clear with no gap
    send(8'h0D);
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    chk("wrap_d_wr", int'(vga_wr_en), 1);
    chk("wrap_d_addr", int'(vga_waddr), 14'h003);
    chk("wrap_d_data", int'(vga_wdata), 8'h44);
    chk("wrap_cursor", int'({cursor_row, cursor_col}), (1 << 8));
    chk("wrap_busy", int'(busy), 1);
    chk("wrap_ready", int'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk48); #1;
      chk($sformatf("wrap_fill%0d_wr", i), int'(vga_wr_en), 1);
      chk($sformatf("wrap_fill%0d_addr", i), int'(vga_waddr), (1 << 8) | i);
      chk($sformatf("wrap_fill%0d_data", i), int'(vga_wdata), 8'h20);
      if (i < 3) chk($sformatf("wrap_fill%0d_ready", i), int'(in_ready), 0);
    end
    chk("wrap_done_ready", int'(in_ready), 1);

    // LF at last row wraps to row 0 and clears it
    send(8'h0A);
    chk("lf_row", int'(cursor_row), 2);
    wait_ready(100);
    @(negedge clk48); #1;
    wq.delete();
    send(8'h0A);
    chk("lf_wrap_cursor", int'({cursor_row, cursor_col}), 0);
    chk("lf_no_write", int'(vga_wr_en), 0);
    begin
      int n = 0;
      while (busy && n < 20) begin
        n++;
        @(posedge clk48); #1;
      end
      chk("lf_busy_cycles", n, 4);
    end
    @(negedge clk48); #1;
    chk("lf_clr_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++)
      chk($sformatf("lf_clr%0d", i), int'(wq[i]), (i << 8) | 8'h20);

    // Reset during a line clear aborts it and restarts the full clear
    send(8'h0A);
    @(posedge clk48); @(posedge clk48);
    @(negedge clk48); rst = 1'b1;
    @(posedge clk48); #1;
    chk("abort_wr_en", int'(vga_wr_en), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_ready", int'(in_ready), 0);
    chk("abort_cursor", int'({cursor_row, cursor_col}), 0);
    @(negedge clk48); rst = 1'b0; wq.delete();
    @(posedge clk48); #1;
    chk("abort_first_addr", int'(vga_waddr), 0);
    wait_ready(100);
    @(negedge clk48); #1;
    check_clear_all();
    chk("abort_end_cursor", int'({cursor_row, cursor_col}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
